// File: rtl/trig_capture_seq_if.sv
// Control, trigger, sample and readout signals of the trigger-capture sequencer.
// The host/control side uses master; the sequencer uses slave.
interface trig_capture_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
);
  logic          arm;
  logic          abort;
  logic          trig;
  logic [DW-1:0] din;
  logic [AW:0]   cap_len;
  logic [7:0]    holdoff;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          armed;
  logic          busy;
  logic          done;
  logic [AW:0]   wr_count;
  logic [7:0]    missed_trig;

  modport master (
    output arm, abort, trig, din, cap_len, holdoff, rd_en,
    input  rd_data, rd_valid, armed, busy, done, wr_count, missed_trig
  );

  modport slave (
    input  arm, abort, trig, din, cap_len, holdoff, rd_en,
    output rd_data, rd_valid, armed, busy, done, wr_count, missed_trig
  );
endinterface

// File: rtl/trig_capture_seq.sv
// Trigger-capture sequencer: arm, qualify a rising trigger edge, wait a holdoff,
// capture a fixed number of samples into a buffer, then serve handshaked reads.
module trig_capture_seq #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    trig_capture_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HOLDOFF,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_trig_q;
    logic          w_trig_rise;
    logic [AW:0]   r_len;
    logic [AW:0]   r_wr_count;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   w_eff_len;
    logic [AW:0]   w_wr_count_inc;
    logic [7:0]    r_hold;
    logic [7:0]    r_hcnt;
    logic [7:0]    r_missed;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_latch;
    logic w_load_hcnt;
    logic w_wr_en;
    logic w_rd_fire;
    logic w_clr_ptr;
    logic w_miss_inc;

    assign w_trig_rise    = bus.trig & ~r_trig_q;
    assign w_wr_count_inc = r_wr_count + LP_ONE;

    // Zero-length requests capture one sample; oversize requests fill the buffer.
    always_comb begin
        w_eff_len = bus.cap_len;
        if (bus.cap_len == '0) begin
            w_eff_len = LP_ONE;
        end else if (bus.cap_len > LP_DEPTH) begin
            w_eff_len = LP_DEPTH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load_hcnt = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_fire   = 1'b0;
        w_clr_ptr   = 1'b0;
        w_miss_inc  = 1'b0;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_clr_ptr   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        w_state_nxt = S_ARMED;
                        w_latch     = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (bus.arm) begin
                        w_latch = 1'b1;
                    end else if (w_trig_rise) begin
                        if (r_hold != 8'd0) begin
                            w_state_nxt = S_HOLDOFF;
                            w_load_hcnt = 1'b1;
                        end else begin
                            w_state_nxt = S_CAPTURE;
                        end
                    end
                end
                S_HOLDOFF: begin
                    w_miss_inc = w_trig_rise;
                    if (r_hcnt == 8'd1) begin
                        w_state_nxt = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    w_miss_inc = w_trig_rise;
                    w_wr_en    = 1'b1;
                    if (w_wr_count_inc == r_len) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.arm) begin
                        w_state_nxt = S_ARMED;
                        w_latch     = 1'b1;
                    end else if (bus.rd_en && (r_rd_ptr < r_wr_count)) begin
                        w_rd_fire = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_q   <= 1'b0;
            r_len      <= '0;
            r_hold     <= '0;
            r_hcnt     <= '0;
            r_wr_count <= '0;
            r_rd_ptr   <= '0;
            r_missed   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_trig_q   <= bus.trig;
            r_rd_valid <= w_rd_fire;
            if (w_load_hcnt) begin
                r_hcnt <= r_hold;
            end else if (r_state == S_HOLDOFF) begin
                r_hcnt <= r_hcnt - 8'd1;
            end
            if (w_clr_ptr) begin
                r_wr_count <= '0;
                r_rd_ptr   <= '0;
            end else if (w_latch) begin
                r_len      <= w_eff_len;
                r_hold     <= bus.holdoff;
                r_wr_count <= '0;
                r_rd_ptr   <= '0;
                r_missed   <= '0;
            end else if (w_wr_en) begin
                r_wr_count <= w_wr_count_inc;
            end else if (w_rd_fire) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + LP_ONE;
            end
            if (w_miss_inc && (r_missed != 8'hFF)) begin
                r_missed <= r_missed + 8'd1;
            end
        end
    end

    // Sample buffer is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_count[AW-1:0]] <= bus.din;
        end
    end

    assign bus.armed       = (r_state == S_ARMED);
    assign bus.busy        = (r_state == S_HOLDOFF) || (r_state == S_CAPTURE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.wr_count    = r_wr_count;
    assign bus.missed_trig = r_missed;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid    = r_rd_valid;

endmodule

// File: tb/tb_trig_capture_seq.sv
// Directed testbench for trig_capture_seq with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_trig_capture_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cnt;

    trig_capture_seq_if #(.DW(8), .AW(4)) bus ();

    trig_capture_seq #(.DW(8), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.arm         = 1'b0;
        bus.abort       = 1'b0;
        bus.trig        = 1'b0;
        bus.din         = 8'h00;
        bus.cap_len     = 5'd0;
        bus.holdoff     = 8'd0;
        bus.rd_en       = 1'b0;
        step(2);
        check("rst_armed",    32'(bus.armed),       32'd0);
        check("rst_busy",     32'(bus.busy),        32'd0);
        check("rst_done",     32'(bus.done),        32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid),    32'd0);
        check("rst_rd_data",  32'(bus.rd_data),     32'd0);
        check("rst_wr_count", 32'(bus.wr_count),    32'd0);
        check("rst_missed",   32'(bus.missed_trig), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic capture: len 4, no holdoff
        bus.cap_len = 5'd4;
        bus.holdoff = 8'd0;
        bus.arm     = 1'b1;
        step(1);
        bus.arm = 1'b0;
        check("b_armed", 32'(bus.armed), 32'd1);
        bus.trig = 1'b1;
        step(1);
        check("b_busy_after_T", 32'(bus.busy), 32'd1);
        bus.trig = 1'b0;
        bus.din = 8'hA1; step(1);
        bus.din = 8'h3C; step(1);
        bus.din = 8'hFF; step(1);
        check("b_not_done_T3", 32'(bus.done), 32'd0);
        bus.din = 8'h55; step(1);
        check("b_done",     32'(bus.done),     32'd1);
        check("b_busy_off", 32'(bus.busy),     32'd0);
        check("b_wr_count", 32'(bus.wr_count), 32'd4);
        bus.rd_en = 1'b1;
        step(1);
        check("b_rv0", 32'(bus.rd_valid), 32'd1);
        check("b_rd0", 32'(bus.rd_data),  32'hA1);
        step(1);
        check("b_rv1", 32'(bus.rd_valid), 32'd1);
        check("b_rd1", 32'(bus.rd_data),  32'h3C);
        step(1);
        check("b_rd2", 32'(bus.rd_data),  32'hFF);
        step(1);
        check("b_rv3", 32'(bus.rd_valid), 32'd1);
        check("b_rd3", 32'(bus.rd_data),  32'h55);
        step(1);
        check("b_rv_extra",   32'(bus.rd_valid), 32'd0);
        check("b_rd_holds",   32'(bus.rd_data),  32'h55);
        bus.rd_en = 1'b0;

        // Holdoff 3, len 2, din = V + k at edge T+k
        bus.cap_len = 5'd2;
        bus.holdoff = 8'd3;
        bus.arm     = 1'b1;
        step(1);
        bus.arm  = 1'b0;
        bus.trig = 1'b1;
        bus.din  = 8'h10;
        step(1);
        bus.trig = 1'b0;
        cnt = bus.busy ? 1 : 0;
        for (int k = 1; k <= 8; k++) begin
            bus.din = 8'(16 + k);
            step(1);
            if (bus.busy) cnt++;
        end
        check("h_busy_cycles", 32'(cnt),          32'd5);
        check("h_done",        32'(bus.done),     32'd1);
        check("h_wr_count",    32'(bus.wr_count), 32'd2);
        bus.rd_en = 1'b1;
        step(1);
        check("h_rd0", 32'(bus.rd_data), 32'h14);
        step(1);
        check("h_rd1", 32'(bus.rd_data), 32'h15);
        bus.rd_en = 1'b0;

        // Level trigger held through arm, then retriggers during capture
        bus.trig = 1'b1;
        step(1);
        bus.cap_len = 5'd16;
        bus.holdoff = 8'd0;
        bus.arm     = 1'b1;
        step(1);
        bus.arm = 1'b0;
        step(3);
        check("l_still_armed", 32'(bus.armed), 32'd1);
        check("l_not_busy",    32'(bus.busy),  32'd0);
        bus.trig = 1'b0;
        step(1);
        check("l_armed_low", 32'(bus.armed), 32'd1);
        bus.trig = 1'b1;
        step(1);
        check("l_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            bus.din  = 8'(k);
            bus.trig = (k == 2) || (k == 4) || (k == 6);
            step(1);
        end
        bus.trig = 1'b0;
        check("l_done",     32'(bus.done),        32'd1);
        check("l_wr_count", 32'(bus.wr_count),    32'd16);
        check("l_missed",   32'(bus.missed_trig), 32'd3);
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("l_rd%0d", k), 32'(bus.rd_data), 32'(k));
        end
        bus.rd_en = 1'b0;

        // cap_len = 0 captures one sample
        bus.cap_len = 5'd0;
        bus.arm     = 1'b1;
        step(1);
        bus.arm  = 1'b0;
        bus.trig = 1'b1;
        bus.din  = 8'h77;
        step(1);
        bus.trig = 1'b0;
        bus.din  = 8'h88;
        step(1);
        check("z_done",     32'(bus.done),     32'd1);
        check("z_wr_count", 32'(bus.wr_count), 32'd1);
        bus.rd_en = 1'b1;
        step(1);
        check("z_rd0", 32'(bus.rd_data), 32'h88);
        step(1);
        check("z_rv_extra", 32'(bus.rd_valid), 32'd0);
        bus.rd_en = 1'b0;

        // cap_len = 31 clamps to 16
        bus.cap_len = 5'd31;
        bus.arm     = 1'b1;
        step(1);
        bus.arm  = 1'b0;
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            bus.din = 8'(32 + k);
            step(1);
            if (k == 15) check("c_not_done_15", 32'(bus.done), 32'd0);
        end
        check("c_done",     32'(bus.done),     32'd1);
        check("c_wr_count", 32'(bus.wr_count), 32'd16);

        // Abort priority
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check("a_idle_done", 32'(bus.done), 32'd0);
        bus.abort = 1'b1;
        bus.arm   = 1'b1;
        step(1);
        bus.abort = 1'b0;
        bus.arm   = 1'b0;
        check("a_arm_blocked", 32'(bus.armed), 32'd0);
        bus.cap_len = 5'd8;
        bus.arm     = 1'b1;
        step(1);
        bus.arm = 1'b0;
        check("a_armed", 32'(bus.armed), 32'd1);
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        bus.din = 8'h01; step(1);
        bus.din = 8'h02; step(1);
        check("a_wr2", 32'(bus.wr_count), 32'd2);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check("a_busy_off",  32'(bus.busy),  32'd0);
        check("a_armed_off", 32'(bus.armed), 32'd0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (bus.done) cnt++;
        end
        check("a_done_never", 32'(cnt), 32'd0);
        bus.cap_len = 5'd4;
        bus.holdoff = 8'd10;
        bus.arm     = 1'b1;
        step(1);
        bus.arm = 1'b0;
        check("a_rearm_wr", 32'(bus.wr_count), 32'd0);
        check("a_rearmed",  32'(bus.armed),    32'd1);

        // Async reset mid-holdoff
        bus.trig = 1'b1;
        step(1);
        check("r_busy", 32'(bus.busy), 32'd1);
        bus.trig = 1'b0;
        step(1);
        bus.trig = 1'b1;
        step(1);
        check("r_missed1", 32'(bus.missed_trig), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_busy0",   32'(bus.busy),        32'd0);
        check("r_armed0",  32'(bus.armed),       32'd0);
        check("r_done0",   32'(bus.done),        32'd0);
        check("r_missed0", 32'(bus.missed_trig), 32'd0);
        check("r_wr0",     32'(bus.wr_count),    32'd0);
        check("r_rv0",     32'(bus.rd_valid),    32'd0);
        @(posedge clk);
        #3;
        rst_n    = 1'b1;
        bus.trig = 1'b0;
        step(1);
        bus.trig = 1'b1;
        step(2);
        check("r_trig_ignored_armed", 32'(bus.armed), 32'd0);
        check("r_trig_ignored_busy",  32'(bus.busy),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trig_capture_seq.md
# trig_capture_seq

Sequencer for the 8-bit trigger-capture path. It arms on command and qualifies a rising edge on `trig`. After a programmable holdoff it records a programmable number of consecutive `din` samples into an internal buffer, then presents the buffer for handshaked readout. It sits between the control/host logic and the raw capture datapath, and owns arming, holdoff, sample counting and readout sequencing.

## Interface
- `DW`, default 8: sample width.
- `DEPTH`, default 16: buffer depth in samples; must be a power of two, 2 or more.
- `AW`, default $clog2(DEPTH): buffer address width.
- `clk`, input, 1: single clock; everything samples on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `arm`, input, 1: level sampled each cycle; arms the capture.
- `abort`, input, 1: returns the block to IDLE from any state.
- `trig`, input, 1: trigger; only a rising edge is used.
- `din`, input, DW: sample data.
- `cap_len`, input, AW+1: number of samples; latched on accepted `arm`.
- `holdoff`, input, 8: cycles between trigger and first sample; latched on accepted `arm`.
- `rd_en`, input, 1: read request, DONE state only.
- `rd_data`, output, DW: registered read data.
- `rd_valid`, output, 1: one-cycle strobe qualifying `rd_data`.
- `armed`, output, 1: high in ARMED.
- `busy`, output, 1: high in HOLDOFF or CAPTURE.
- `done`, output, 1: high in DONE.
- `wr_count`, output, AW+1: samples written in the current capture.
- `missed_trig`, output, 8: saturating count of rising edges ignored while busy.

## Operation
- States are IDLE, ARMED, HOLDOFF, CAPTURE and DONE. `armed`, `busy` and `done` are decoded from registered state.
- Trigger edge: `trig_q` is `trig` registered every cycle in every state and resets to 0. `trig_rise = trig & ~trig_q`. If `trig` is already high when the block arms, it does not fire; a fresh edge is needed.
- Length rule: effective length = `cap_len` when it is 1..DEPTH. 0 maps to 1. Any value above DEPTH clamps to DEPTH.
- IDLE -> ARMED on `arm`. This latches the effective length and `holdoff`, and clears `wr_count`, the read pointer and `missed_trig`.
- ARMED:
  - `arm` again re-latches the configuration and stays in ARMED.
  - `trig_rise` moves to HOLDOFF when latched holdoff > 0, otherwise to CAPTURE.
- HOLDOFF: a down-counter loaded with the latched holdoff decrements each cycle. It moves to CAPTURE in the cycle the counter reaches 1.
- CAPTURE:
  - Each cycle writes `din` to buffer[`wr_count`[AW-1:0]] and increments `wr_count`.
  - After the write that makes `wr_count` equal the effective length, go to DONE.
- HOLDOFF/CAPTURE extras:
  - Each `trig_rise` increments `missed_trig`, saturating at 255.
  - `arm` is ignored in these states.
- DONE:
  - `rd_en` with read pointer < `wr_count`: register buffer[ptr] into `rd_data`, pulse `rd_valid` and increment the pointer.
  - `rd_en` once the pointer equals `wr_count`: ignored; `rd_valid` stays 0 and `rd_data` holds.
  - `arm` re-arms as from IDLE.
- `rd_en` outside DONE is ignored.
- `abort` in any state goes to IDLE and clears the pointers. `abort` wins over a simultaneous `arm`, `trig_rise` or `rd_en`. Buffer contents are not cleared.

## Timing
- Reset values: state IDLE; `armed`, `busy`, `done`, `rd_valid` = 0; `rd_data` = 0; `wr_count` = 0; `missed_trig` = 0; `trig_q` = 0; counters and pointers 0. The buffer is not reset.
- `arm` sampled at edge A: `armed` is high after A. A `trig` rise sampled at A itself is not accepted.
- Trigger accepted at edge T with holdoff H and length L:
  - `busy` is high from after T.
  - Samples are `din` at edges T+1+H through T+H+L.
  - `done` rises after edge T+H+L.
  - `wr_count` reads L once `done` is high.
- Read latency is 1 cycle: `rd_en` sampled at edge R gives `rd_data`/`rd_valid` valid after R, for one cycle.
- Back-to-back `rd_en` gives one sample per cycle.
- `rst_n` low mid-capture or mid-read forces the reset values immediately.

## Test plan
- Basic capture:
  - Stimulus: reset; `arm` with `cap_len`=4, `holdoff`=0; `trig` rise at T; `din` = A1,3C,FF,55 on edges T+1..T+4; then 4 `rd_en`.
  - Required: `done` after T+4; reads return A1,3C,FF,55 with one `rd_valid` each.
  - A 5th `rd_en` gives no `rd_valid`.
- Holdoff:
  - Stimulus: `holdoff`=3, `cap_len`=2, `din` incrementing by 1 per cycle, value V at edge T.
  - Required: buffer holds V+4, V+5; `busy` high for exactly 5 cycles.
- Level trigger and retriggers:
  - Stimulus: `trig` held high before and through `arm`.
  - Required: the block stays ARMED until `trig` goes low, then high again.
  - Stimulus: 3 further rises during CAPTURE of `cap_len`=16.
  - Required: `missed_trig`=3; capture is unaffected.
- Length clamps:
  - `cap_len`=0 captures 1 sample.
  - `cap_len`=31 with DEPTH=16 captures 16 samples; `wr_count`=16.
- Abort priority:
  - `abort` with `arm` in IDLE: the block stays IDLE.
  - `abort` in CAPTURE after 2 samples: IDLE next cycle, `busy`=0, `done` never asserts.
  - A re-arm then clears `wr_count` to 0.
- Async reset:
  - Stimulus: `rst_n` low mid-HOLDOFF, asynchronous to `clk`.
  - Required: all outputs reach reset values before the next edge.
  - After release, `trig` is ignored until `arm`.
